mem_debug_uart_tx: RTL
======================

Name: mem_debug_uart_tx

Overview:
- Transmit side of the debug/UART memory-access path.
- Accepts 42-bit read-back frames from data/instruction memories: a frame word plus a one-cycle ready pulse from the memory's tx-data-ready output.
- Buffers each frame and serializes it on a UART TX line as a 7-byte packet, each byte 8N1, LSB first.
- Sits between the memory debug ports and the chip-level uart_tx pin.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal values are >= 2.
- HEADER_BYTE, 8'hA5, sync byte sent first in every packet.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- tx_frame_in  input  42  frame layout: [41] mem type (0 = data, 1 = instr); [40:32] target addr; [31:0] data
- tx_frame_valid  input  1  one-cycle strobe; tx_frame_in is sampled on the same edge
- uart_tx  output  1  serial line; idle level is high
- tx_busy  output  1  high while a packet is being shifted out
- tx_done  output  1  one-cycle pulse after the last stop bit of each packet
- tx_overflow  output  1  one-cycle pulse when a frame is dropped

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous, active-low.
- Reset values: uart_tx=1, tx_busy=0, tx_done=0, tx_overflow=0. FSM goes to IDLE; the active frame, pending frame and all counters clear.
- Reset asserted mid-packet: the line returns high immediately (asynchronously); no partial recovery.
- Packet contents: 48-bit word = {6'b0, frame}. Bytes go out in this order:
  - HEADER_BYTE
  - word[47:40], word[39:32], word[31:24], word[23:16], word[15:8], word[7:0]
- Byte format: start bit (0), d0..d7, stop bit (1). Each bit holds for exactly CLKS_PER_BIT cycles.
- No gap between bytes inside a packet. One packet lasts 70*CLKS_PER_BIT cycles.
- Buffering: one active register plus one pending slot (pend_valid).
- FSM states and transitions:
  - IDLE: if pend_valid, move pending to active, clear pend_valid, go to START. Else if tx_frame_valid, load active directly, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, bit_idx 0..7, then STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. If byte_idx<6, increment byte_idx and go to START. Else assert tx_done for one cycle and go to IDLE.
- Latency: a strobe accepted in IDLE drives uart_tx low on the first cycle after the sampling edge.
- Back-to-back packets: exactly one IDLE cycle (line high) separates them.
- tx_busy is 1 in START/DATA/STOP and 0 in IDLE.
- Strobe while not IDLE and pend_valid=0: the frame goes to the pending slot.
- Strobe while pend_valid=1: the frame is dropped and tx_overflow pulses; the existing pending frame is kept.
- Strobe in the IDLE cycle that moves pending to active: the new frame goes to the pending slot; no overflow.
- Strobe in IDLE with no pending frame: load it directly. Pending and active are never both loaded from the same strobe.
- Counters:
  - baud_cnt: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - bit_idx: 3 bits. byte_idx: 3 bits, values 0..6.
- tx_frame_in is ignored when tx_frame_valid=0.

Decomposition:
- Package mem_debug_pkg holds:
  - DBG_FRAME_W=42, DBG_PKT_BYTES=7, DBG_HEADER=8'hA5
  - tx state enum {IDLE, START, DATA, STOP}
  - frame field offsets: TYPE_BIT=41, ADDR_MSB=40, ADDR_LSB=32
- One sub-module, uart_tx_byte, owns baud_cnt, bit_idx and the START/DATA/STOP sequencing.
  - Handshake: byte_valid/byte_ready; byte_done pulses after the stop bit.
- The top level owns the packet FSM, byte_idx, the pending buffer and overflow/done generation.

Test Plan (CLKS_PER_BIT=4):
- Reset idle: hold reset_n=0 for 5 cycles, then release -> uart_tx=1 and all pulses 0 for 100 cycles.
- Single frame: tx_frame_in={1'b0,9'h005,32'hDEADBEEF}, one strobe -> decoded bytes A5 00 05 DE AD BE EF; uart_tx low 1 cycle after the strobe; tx_done pulses 280 cycles after the first start bit; tx_busy high throughout.
- Field packing: {1'b1,9'h1FF,32'h00000001} -> bytes A5 03 FF 00 00 00 01.
- Back-to-back: frame A, then frame B strobed 50 cycles later -> A sent, exactly 1 idle-high cycle, then B; no overflow.
- Overflow: strobes A, B, C within 10 cycles -> A and B transmitted, C dropped, tx_overflow pulses exactly once (on C's strobe edge).
- Reset mid-byte: assert reset_n=0 during DATA of byte 3 -> uart_tx=1 immediately, tx_busy=0; a new strobe after release sends a full 7-byte packet starting with A5.

Source files
------------

// File: rtl/mem_debug_pkg.sv
// Shared types and constants for the memory debug UART transmit path.
package mem_debug_pkg;

    localparam int         DBG_FRAME_W   = 42;
    localparam int         DBG_PKT_BYTES = 7;
    localparam logic [7:0] DBG_HEADER    = 8'hA5;

    // Frame field positions: [41] mem type, [40:32] target addr, [31:0] data
    localparam int TYPE_BIT = 41;
    localparam int ADDR_MSB = 40;
    localparam int ADDR_LSB = 32;

    // Byte serializer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Packet-level states: waiting for a frame, or shifting out a packet
    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_SEND = 1'b1
    } pkt_state_t;

    // Byte idx of a packet: 0 is the header, 1..6 walk the zero-extended
    // 48-bit word from its most significant byte down.
    function automatic logic [7:0] pkt_byte(
        input logic [DBG_FRAME_W-1:0] frame,
        input logic [2:0]             idx,
        input logic [7:0]             header
    );
        logic [47:0] word;
        logic [7:0]  result;
        word = {6'b000000, frame[TYPE_BIT], frame[ADDR_MSB:ADDR_LSB], frame[ADDR_LSB-1:0]};
        case (idx)
            3'd0:    result = header;
            3'd1:    result = word[47:40];
            3'd2:    result = word[39:32];
            3'd3:    result = word[31:24];
            3'd4:    result = word[23:16];
            3'd5:    result = word[15:8];
            3'd6:    result = word[7:0];
            default: result = 8'hFF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Accepts a byte when ready, shifts it LSB first, and
// can chain straight into the next byte on the last cycle of the stop bit so
// consecutive bytes have no gap.
module uart_tx_byte
    import mem_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_ready,
    output logic       o_byte_done,
    output logic       o_tx
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_line;
    logic              w_bit_end;

    assign w_bit_end    = (r_baud_cnt == BAUD_LAST);
    // Done marks the final cycle of the stop bit; a new byte may be taken then.
    assign o_byte_done  = (r_state == STOP) && w_bit_end;
    assign o_byte_ready = (r_state == IDLE) || o_byte_done;
    assign o_tx         = r_line;

    // Bit sequencing: start, eight data bits LSB first, stop; line is registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_line     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
                    if (i_byte_valid) begin
                        r_shift <= i_byte_data;
                        r_line  <= 1'b0;
                        r_state <= START;
                    end else begin
                        r_line  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_line     <= r_shift[0];
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_line  <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_line    <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        if (i_byte_valid) begin
                            r_shift <= i_byte_data;
                            r_line  <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_line  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_debug_uart_tx.sv
// Memory debug read-back transmitter: buffers 42-bit frames (one active,
// one pending) and sends each as a 7-byte UART packet led by a header byte.
module mem_debug_uart_tx
    import mem_debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER_BYTE  = DBG_HEADER
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DBG_FRAME_W-1:0] tx_frame_in,
    input  logic                   tx_frame_valid,
    output logic                   uart_tx,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_overflow
);

    localparam logic [2:0] LAST_BYTE = 3'(DBG_PKT_BYTES - 1);

    pkt_state_t             r_pkt_state;
    logic [DBG_FRAME_W-1:0] r_active;
    logic [DBG_FRAME_W-1:0] r_pend;
    logic                   r_pend_valid;
    logic [2:0]             r_byte_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_byte_ready;
    logic       w_byte_done;
    logic       w_tx_line;

    // Byte offered to the serializer: header at packet start, then frame bytes
    always_comb begin
        w_byte_valid = 1'b0;
        w_byte_data  = HEADER_BYTE;
        if (r_pkt_state == PKT_IDLE) begin
            w_byte_valid = r_pend_valid || tx_frame_valid;
            w_byte_data  = HEADER_BYTE;
        end else begin
            w_byte_valid = (r_byte_idx < LAST_BYTE);
            w_byte_data  = pkt_byte(r_active, r_byte_idx + 3'd1, HEADER_BYTE);
        end
    end

    // Packet FSM with pending slot, byte counter and done/overflow pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_state  <= PKT_IDLE;
            r_active     <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_byte_idx   <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            case (r_pkt_state)
                PKT_IDLE: begin
                    r_byte_idx <= 3'd0;
                    if (w_byte_ready && r_pend_valid) begin
                        // Pending frame wins; a same-cycle strobe refills the slot
                        r_active    <= r_pend;
                        r_pkt_state <= PKT_SEND;
                        r_busy      <= 1'b1;
                        if (tx_frame_valid) begin
                            r_pend <= tx_frame_in;
                        end else begin
                            r_pend_valid <= 1'b0;
                        end
                    end else if (w_byte_ready && tx_frame_valid) begin
                        r_active    <= tx_frame_in;
                        r_pkt_state <= PKT_SEND;
                        r_busy      <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                PKT_SEND: begin
                    if (tx_frame_valid) begin
                        if (r_pend_valid) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_pend       <= tx_frame_in;
                            r_pend_valid <= 1'b1;
                        end
                    end
                    if (w_byte_done) begin
                        if (r_byte_idx < LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end else begin
                            r_pkt_state <= PKT_IDLE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_pkt_state <= PKT_IDLE;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_byte_valid (w_byte_valid),
        .i_byte_data  (w_byte_data),
        .o_byte_ready (w_byte_ready),
        .o_byte_done  (w_byte_done),
        .o_tx         (w_tx_line)
    );

    assign uart_tx     = w_tx_line;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_overflow = r_overflow;

endmodule
